// File: rtl/a_mx_accum_pkg.sv
// -----------------------------------------------------------------------------
// a_mx_accum_pkg
// Shared definitions for the graph-convolution accumulator:
//   - default vector length, data, accumulator, rounding and output widths
//   - FSM state encoding (ACC = 0, FLUSH = 1, DRAIN = 2)
//   - round-half-up + saturate helper used on the drain path
// -----------------------------------------------------------------------------
package a_mx_accum_pkg;

    localparam int MX_N     = 25;
    localparam int MX_DW    = 16;
    localparam int MX_ACC_W = 40;
    localparam int MX_FRAC  = 8;
    localparam int MX_OUT_W = 16;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Round half up, arithmetic shift right by frac, then clamp to a signed
    // out_w-bit range. Works on a 64-bit sign-extended accumulator so the
    // rounding add can never wrap for any accumulator width up to 63 bits.
    function automatic logic signed [63:0] round_sat(
        input logic signed [63:0] acc,
        input int                 frac,
        input int                 out_w
    );
        logic signed [63:0] r;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        logic signed [63:0] res;
        r     = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
        max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        min_v = ~max_v;
        if (r > max_v) begin
            res = max_v;
        end else if (r < min_v) begin
            res = min_v;
        end else begin
            res = r;
        end
        return res;
    endfunction

endpackage

// File: rtl/a_mx_accum_mac_lane.sv
// -----------------------------------------------------------------------------
// a_mx_accum_mac_lane
// One row of the accumulator: a registered product stage followed by a
// wrapping accumulator with synchronous clear.
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-low reset (clears the accumulator)
//   load_i  in   capture a_i * x_i into the product register
//   a_i     in   A coefficient for this row (signed DW)
//   x_i     in   feature scalar (signed DW)
//   add_i   in   add the product register into the accumulator
//   clr_i   in   clear the accumulator (end of frame)
//   acc_o   out  current accumulator value (signed ACC_W)
// -----------------------------------------------------------------------------
module a_mx_accum_mac_lane
    import a_mx_accum_pkg::*;
#(
    parameter int DW    = MX_DW,
    parameter int ACC_W = MX_ACC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_i,
    input  logic signed [DW-1:0]    a_i,
    input  logic signed [DW-1:0]    x_i,
    input  logic                    add_i,
    input  logic                    clr_i,
    output logic signed [ACC_W-1:0] acc_o
);

    logic signed [2*DW-1:0]  prod_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;

    // Stage 1: product register. Pure datapath, qualified by add_i downstream,
    // so it carries no reset.
    always_ff @(posedge clk) begin
        if (load_i) begin
            prod_q <= a_i * x_i;
        end
    end

    // Stage 2: accumulator. Clear only happens in DRAIN while add_i is only
    // raised in the cycle after a fire, so the two never coincide.
    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (add_i) begin
            acc_d = acc_q + {{(ACC_W-2*DW){prod_q[2*DW-1]}}, prod_q};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/a_mx_accum.sv
// -----------------------------------------------------------------------------
// a_mx_accum
// Graph-convolution accumulator downstream of the A-matrix column streamer.
// Accumulates acc[i] += A[i][c] * x[c] over N columns, then drains N rounded,
// saturated rows one per handshake, throttling the streamer through halt.
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-low reset
//   mx_v        in   A column valid
//   mx_col      in   A column, element i at [i*DW +: DW]
//   feat_v      in   feature scalar valid
//   feat        in   feature scalar x[c]
//   feat_rdy    out  feature consumed this cycle (fire)
//   halt        out  streamer must freeze
//   out_v       out  result valid (state DRAIN)
//   out_idx     out  row index of out_data
//   out_data    out  rounded, saturated result row
//   out_rdy     in   downstream accepts result
//   frame_done  out  one-cycle pulse after row N-1 is accepted
// -----------------------------------------------------------------------------
module a_mx_accum
    import a_mx_accum_pkg::*;
#(
    parameter int N     = MX_N,
    parameter int DW    = MX_DW,
    parameter int ACC_W = MX_ACC_W,
    parameter int FRAC  = MX_FRAC,
    parameter int OUT_W = MX_OUT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mx_v,
    input  logic [N*DW-1:0]      mx_col,
    input  logic                 feat_v,
    input  logic [DW-1:0]        feat,
    output logic                 feat_rdy,
    output logic                 halt,
    output logic                 out_v,
    output logic [4:0]           out_idx,
    output logic [OUT_W-1:0]     out_data,
    input  logic                 out_rdy,
    output logic                 frame_done
);

    localparam int CW = $clog2(N + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   col_cnt_q, col_cnt_d;
    logic [4:0]      idx_q, idx_d;
    logic            p_v_q, p_v_d;
    logic            done_q, done_d;
    logic            clr;
    logic            fire;

    logic signed [ACC_W-1:0] acc_w [N];
    logic signed [ACC_W-1:0] acc_sel;
    logic signed [63:0]      rs;

    assign fire     = (state_q == ST_ACC) & mx_v & feat_v & (col_cnt_q < CW'(N));
    assign feat_rdy = fire;
    assign halt     = (state_q != ST_ACC) | ~feat_v;

    // Per-row product + accumulator lanes
    for (genvar i = 0; i < N; i++) begin : g_lane
        a_mx_accum_mac_lane #(
            .DW    (DW),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .load_i (fire),
            .a_i    ($signed(mx_col[i*DW +: DW])),
            .x_i    ($signed(feat)),
            .add_i  (p_v_q),
            .clr_i  (clr),
            .acc_o  (acc_w[i])
        );
    end

    // Next-state and control
    always_comb begin
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        clr       = 1'b0;
        p_v_d     = fire;
        case (state_q)
            ST_ACC: begin
                if (fire) begin
                    col_cnt_d = col_cnt_q + CW'(1);
                    if (col_cnt_q == CW'(N - 1)) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            // One cycle lets the final product land in the accumulators.
            ST_FLUSH: begin
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_rdy) begin
                    if (idx_q == 5'(N - 1)) begin
                        idx_d     = '0;
                        col_cnt_d = '0;
                        clr       = 1'b1;
                        done_d    = 1'b1;
                        state_d   = ST_ACC;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_ACC;
            col_cnt_q <= '0;
            idx_q     <= '0;
            p_v_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_cnt_q <= col_cnt_d;
            idx_q     <= idx_d;
            p_v_q     <= p_v_d;
            done_q    <= done_d;
        end
    end

    // Output mux and round/saturate. idx_q only changes on acceptance, so
    // out_idx/out_data hold while out_rdy is low.
    assign acc_sel    = acc_w[idx_q];
    assign rs         = round_sat({{(64-ACC_W){acc_sel[ACC_W-1]}}, acc_sel}, FRAC, OUT_W);
    assign out_v      = (state_q == ST_DRAIN);
    assign out_idx    = idx_q;
    assign out_data   = out_v ? rs[OUT_W-1:0] : '0;
    assign frame_done = done_q;

endmodule
